xg_rst_sequencer: RTL and testbench

- Parametrised reset sequencer for multi-lane 10G SFP designs.
- Replaces the fixed power-on counter plus single reset fan-out with the following sequence:
  - hold all PCS/PMA channels in reset;
  - release the channels one at a time, staggered;
  - wait for every channel's resetdone, with timeout and bounded retry;
  - require a settle window before releasing the user-logic reset.
- Sits between the board clock domain and the xg_pcs_pma instances/fpga_core.
- Restarts the sequence on a debounced switch press or on loss of any channel's resetdone.

---
 rtl/xg_rst_sequencer_pkg.sv | 37 +++
 rtl/xg_rst_sequencer_if.sv | 25 ++
 rtl/xg_rst_sequencer_debounce.sv | 52 +++++
 rtl/xg_rst_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_xg_rst_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/xg_rst_sequencer_pkg.sv
// Shared types and sizing helpers for the 10G multi-lane reset sequencer.
// Imported by the sequencer top and its debounce sub-block.
package xg_rst_pkg;

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_RELEASE   = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_SETTLE    = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_e;

  // Transition precedence inside the FSM, highest first.
  typedef enum int {
    PRIO_SW_PRESS  = 0,
    PRIO_TIMEOUT   = 1,
    PRIO_DONE_LOSS = 2,
    PRIO_NORMAL    = 3
  } prio_e;

  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Width of the shared down-counter: it is loaded with (cycles - 1) for every phase.
  function automatic int cnt_w(input int hold, input int stagger, input int timeout,
                               input int settle);
    int m;
    m = hold;
    if (stagger > m) m = stagger;
    if (timeout > m) m = timeout;
    if (settle  > m) m = settle;
    return clog2_min1(m);
  endfunction

endpackage

// File: rtl/xg_rst_sequencer_if.sv
// Board-side bundle of the reset sequencer: push-button, channel resetdone/reset,
// user reset and status/debug outputs.
interface xg_rst_sequencer_if #(
  parameter int NUM_CH  = 2,
  parameter int RETRY_W = 2
);
  logic               sw;
  logic [NUM_CH-1:0]  ch_done;
  logic [NUM_CH-1:0]  ch_rst;
  logic               sys_rst;
  logic               led;
  logic               error;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         state;

  modport master (
    output sw, ch_done,
    input  ch_rst, sys_rst, led, error, retry_cnt, state
  );

  modport slave (
    input  sw, ch_done,
    output ch_rst, sys_rst, led, error, retry_cnt, state
  );
endinterface

// File: rtl/xg_rst_sequencer_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-high counter and a single
// press pulse per button hold (the button must return low to re-arm).
module xg_rst_debounce
  import xg_rst_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sw,
  output logic o_press
);

  localparam int DW = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_fired;
  logic          r_press;
  logic [DW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_fired <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking everywhere here, so each flop samples pre-edge values
      // and the synchroniser really is two stages deep.
      r_meta  <= i_sw;
      r_sync  <= r_meta;
      r_press <= 1'b0;
      if (!r_sync) begin
        r_cnt   <= '0;
        r_fired <= 1'b0;
      end else if (!r_fired) begin
        if (r_cnt == LAST) begin
          r_press <= 1'b1;
          r_fired <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/xg_rst_sequencer.sv
// Staggered PCS/PMA channel reset sequencer with resetdone timeout, bounded retry,
// settle window before user reset release, and switch / done-loss restart.
module xg_rst_sequencer
  import xg_rst_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int HOLD_CYCLES     = 2**24,
  parameter int STAGGER_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES  = 2**22,
  parameter int SETTLE_CYCLES   = 4096,
  parameter int MAX_RETRY       = 3,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int LED_DIV         = 23
) (
  input logic               clk,
  input logic               rst,
  xg_rst_sequencer_if.slave bus
);

  localparam int CW      = cnt_w(HOLD_CYCLES, STAGGER_CYCLES, TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int IDX_W   = clog2_min1(NUM_CH);

  localparam logic [CW-1:0]      HOLD_LOAD    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]      STAGGER_LOAD = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0]      TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]      SETTLE_LOAD  = CW'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
  localparam logic [IDX_W-1:0]   LAST_CH      = IDX_W'(NUM_CH - 1);

  logic [NUM_CH-1:0]  r_done_meta;
  logic [NUM_CH-1:0]  r_done_sync;
  logic               w_all_done;
  logic               w_sw_press;

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_CH-1:0]  r_ch_rst;
  logic               r_sys_rst;
  logic               r_error;
  logic [RETRY_W-1:0] r_retry;
  logic [LED_DIV:0]   r_blink;

  // NOTE: synchronisers are cleared by rst like any other flop so a reset always
  // starts from a known "not done" view of the channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done_meta <= '0;
      r_done_sync <= '0;
      r_blink     <= '0;
    end else begin
      r_done_meta <= bus.ch_done;
      r_done_sync <= r_done_meta;
      r_blink     <= r_blink + 1'b1;
    end
  end

  assign w_all_done = &r_done_sync;

  xg_rst_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_sw    (bus.sw),
    .o_press (w_sw_press)
  );

  // One shared down-counter, reloaded with (cycles - 1) on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_HOLD;
      r_cnt     <= HOLD_LOAD;
      r_idx     <= '0;
      r_ch_rst  <= '1;
      r_sys_rst <= 1'b1;
      r_error   <= 1'b0;
      r_retry   <= '0;
    end else if (w_sw_press) begin
      r_state   <= S_HOLD;
      r_cnt     <= HOLD_LOAD;
      r_idx     <= '0;
      r_ch_rst  <= '1;
      r_sys_rst <= 1'b1;
      r_error   <= 1'b0;
      r_retry   <= '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == '0) begin
            if (NUM_CH == 1) begin
              r_state  <= S_WAIT_DONE;
              r_cnt    <= TIMEOUT_LOAD;
              r_ch_rst <= '0;
            end else begin
              r_state     <= S_RELEASE;
              r_cnt       <= STAGGER_LOAD;
              r_idx       <= IDX_W'(1);
              r_ch_rst[0] <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_RELEASE: begin
          if (r_cnt == '0) begin
            r_ch_rst[r_idx] <= 1'b0;
            if (r_idx == LAST_CH) begin
              r_state <= S_WAIT_DONE;
              r_cnt   <= TIMEOUT_LOAD;
            end else begin
              r_idx <= r_idx + 1'b1;
              r_cnt <= STAGGER_LOAD;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_WAIT_DONE: begin
          // Timeout outranks a simultaneous all-done.
          if (r_cnt == '0) begin
            r_ch_rst <= '1;
            if (r_retry == RETRY_MAX) begin
              r_state <= S_FAIL;
              r_error <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= S_HOLD;
              r_cnt   <= HOLD_LOAD;
              r_retry <= r_retry + 1'b1;
            end
          end else if (w_all_done) begin
            r_state <= S_SETTLE;
            r_cnt   <= SETTLE_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_SETTLE: begin
          if (!w_all_done) begin
            r_cnt <= SETTLE_LOAD;
          end else if (r_cnt == '0) begin
            r_state   <= S_RUN;
            r_cnt     <= '0;
            r_sys_rst <= 1'b0;
            r_retry   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        S_RUN: begin
          if (!w_all_done) begin
            r_state   <= S_HOLD;
            r_cnt     <= HOLD_LOAD;
            r_ch_rst  <= '1;
            r_sys_rst <= 1'b1;
          end
        end

        S_FAIL: begin
          r_ch_rst  <= '1;
          r_sys_rst <= 1'b1;
        end

        default: begin
          r_state   <= S_HOLD;
          r_cnt     <= HOLD_LOAD;
          r_ch_rst  <= '1;
          r_sys_rst <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ch_rst    = r_ch_rst;
  assign bus.sys_rst   = r_sys_rst;
  assign bus.error     = r_error;
  assign bus.retry_cnt = r_retry;
  assign bus.state     = r_state;
  assign bus.led       = (r_state == S_RUN)  ? 1'b1 :
                         (r_state == S_FAIL) ? r_blink[LED_DIV-2] : r_blink[LED_DIV];

endmodule

// File: tb/tb_xg_rst_sequencer.sv
// Scoreboard bench for xg_rst_sequencer: directed stimulus queues cycle-stamped
// expected output tuples; a negedge monitor pops and compares them.
module tb_xg_rst_sequencer;
  import xg_rst_pkg::*;

  localparam int NUM_CH  = 2;
  localparam int RETRY_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  xg_rst_sequencer_if #(.NUM_CH(NUM_CH), .RETRY_W(RETRY_W)) bus ();

  xg_rst_sequencer #(
    .NUM_CH          (NUM_CH),
    .HOLD_CYCLES     (16),
    .STAGGER_CYCLES  (4),
    .TIMEOUT_CYCLES  (64),
    .SETTLE_CYCLES   (8),
    .MAX_RETRY       (2),
    .DEBOUNCE_CYCLES (4),
    .LED_DIV         (23)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned t;
    string       name;
    logic [9:0]  v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned tcyc     = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) tcyc <= tcyc + 1;

  // Tuple layout: {state[2:0], ch_rst[1:0], sys_rst, error, retry_cnt[1:0], led}
  task automatic ex(input int unsigned base, input int n, input string name, input state_e st,
                    input logic [1:0] ch, input logic sys, input logic err,
                    input logic [1:0] rty, input logic led);
    exp_t e;
    e.t    = base + n;
    e.name = $sformatf("%s_n%0d", name, n);
    e.v    = {st, ch, sys, err, rty, led};
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got st=%0d ch_rst=%b sys_rst=%b err=%b retry=%0d led=%b, want st=%0d ch_rst=%b sys_rst=%b err=%b retry=%0d led=%b",
               name, act[9:7], act[6:5], act[4], act[3], act[2:1], act[0],
               exp[9:7], exp[6:5], exp[4], exp[3], exp[2:1], exp[0]);
    end
  endtask

  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].t <= tcyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.t < tcyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", mon_e.name, mon_e.t, tcyc);
      end else begin
        check(mon_e.name, {bus.state, bus.ch_rst, bus.sys_rst, bus.error, bus.retry_cnt, bus.led},
              mon_e.v);
      end
    end
  end

  task automatic wait_t(input int unsigned t);
    while (tcyc < t) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", tcyc);
    $fatal(1, "watchdog");
  end

  int unsigned b1, b2, b3;

  initial begin
    bus.sw      = 1'b0;
    bus.ch_done = 2'b00;
    rst         = 1'b1;
    repeat (2) @(negedge clk);

    // Phase 1: nominal bring-up, run loss, settle glitch, short switch pulse.
    b1 = tcyc + 2;
    ex(b1, -1, "rst",     S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b1,  0, "nom",     S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b1, 15, "nom",     S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b1, 16, "nom",     S_RELEASE,   2'b10, 1, 0, 0, 0);
    ex(b1, 19, "nom",     S_RELEASE,   2'b10, 1, 0, 0, 0);
    ex(b1, 20, "nom",     S_WAIT_DONE, 2'b00, 1, 0, 0, 0);
    ex(b1, 31, "nom",     S_WAIT_DONE, 2'b00, 1, 0, 0, 0);
    ex(b1, 32, "nom",     S_SETTLE,    2'b00, 1, 0, 0, 0);
    ex(b1, 39, "nom",     S_SETTLE,    2'b00, 1, 0, 0, 0);
    ex(b1, 40, "nom",     S_RUN,       2'b00, 0, 0, 0, 1);
    ex(b1, 45, "nom",     S_RUN,       2'b00, 0, 0, 0, 1);
    ex(b1, 51, "loss",    S_RUN,       2'b00, 0, 0, 0, 1);
    ex(b1, 52, "loss",    S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b1, 67, "loss",    S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b1, 68, "loss",    S_RELEASE,   2'b10, 1, 0, 0, 0);
    ex(b1, 72, "loss",    S_WAIT_DONE, 2'b00, 1, 0, 0, 0);
    ex(b1, 73, "glitch",  S_SETTLE,    2'b00, 1, 0, 0, 0);
    ex(b1, 78, "glitch",  S_SETTLE,    2'b00, 1, 0, 0, 0);
    ex(b1, 86, "glitch",  S_SETTLE,    2'b00, 1, 0, 0, 0);
    ex(b1, 87, "glitch",  S_RUN,       2'b00, 0, 0, 0, 1);
    ex(b1, 95, "sw3",     S_RUN,       2'b00, 0, 0, 0, 1);
    ex(b1, 100, "sw3",    S_RUN,       2'b00, 0, 0, 0, 1);
    wait_t(b1);
    rst = 1'b0;
    wait_t(b1 + 29); bus.ch_done = 2'b11;
    wait_t(b1 + 49); bus.ch_done = 2'b10;
    wait_t(b1 + 54); bus.ch_done = 2'b11;
    // Input low for cycle 77 only: synchronised low in cycle 78 = settle count 5.
    wait_t(b1 + 76); bus.ch_done = 2'b01;
    wait_t(b1 + 77); bus.ch_done = 2'b11;
    wait_t(b1 + 89); bus.sw = 1'b1;
    wait_t(b1 + 92); bus.sw = 1'b0;
    wait_t(b1 + 101);

    // Phase 2: channels never report done -> two retries, FAIL, switch recovery.
    rst         = 1'b1;
    bus.ch_done = 2'b00;
    b2 = tcyc + 3;
    ex(b2, -2,  "rst2",   S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b2, 16,  "tmo",    S_RELEASE,   2'b10, 1, 0, 0, 0);
    ex(b2, 20,  "tmo",    S_WAIT_DONE, 2'b00, 1, 0, 0, 0);
    ex(b2, 83,  "tmo",    S_WAIT_DONE, 2'b00, 1, 0, 0, 0);
    ex(b2, 84,  "tmo",    S_HOLD,      2'b11, 1, 0, 1, 0);
    ex(b2, 100, "tmo",    S_RELEASE,   2'b10, 1, 0, 1, 0);
    ex(b2, 104, "tmo",    S_WAIT_DONE, 2'b00, 1, 0, 1, 0);
    ex(b2, 167, "tmo",    S_WAIT_DONE, 2'b00, 1, 0, 1, 0);
    ex(b2, 168, "tmo",    S_HOLD,      2'b11, 1, 0, 2, 0);
    ex(b2, 251, "tmo",    S_WAIT_DONE, 2'b00, 1, 0, 2, 0);
    ex(b2, 252, "fail",   S_FAIL,      2'b11, 1, 1, 2, 0);
    ex(b2, 260, "fail",   S_FAIL,      2'b11, 1, 1, 2, 0);
    ex(b2, 275, "sw6",    S_FAIL,      2'b11, 1, 1, 2, 0);
    ex(b2, 276, "sw6",    S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b2, 291, "sw6",    S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b2, 292, "sw6",    S_RELEASE,   2'b10, 1, 0, 0, 0);
    ex(b2, 293, "arst",   S_RELEASE,   2'b10, 1, 0, 0, 0);
    ex(b2, 294, "arst",   S_HOLD,      2'b11, 1, 0, 0, 0);
    wait_t(b2);
    rst = 1'b0;
    wait_t(b2 + 269); bus.sw = 1'b1;
    wait_t(b2 + 275); bus.sw = 1'b0;

    // Phase 3: reset asserted just after an edge, mid-RELEASE; seen before the next edge.
    wait_t(b2 + 293);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    b3 = tcyc + 3;
    ex(b3, -1, "arst",    S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b3,  0, "arst",    S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b3, 15, "arst",    S_HOLD,      2'b11, 1, 0, 0, 0);
    ex(b3, 16, "arst",    S_RELEASE,   2'b10, 1, 0, 0, 0);
    ex(b3, 20, "arst",    S_WAIT_DONE, 2'b00, 1, 0, 0, 0);
    wait_t(b3);
    rst = 1'b0;
    wait_t(b3 + 22);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
